// File: rtl/alarm_arbiter.sv
// alarm_arbiter
// Shares one W-bit countdown alarm between N requesters with round-robin
// ownership. The owner's timeout is loaded at grant, counted down on tick,
// and a one-cycle done pulse is returned to the owner on expiry.
//
// Ports
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset, clears all state
//   tick   : count enable (prescaler strobe, may be tied high)
//   req    : [N-1:0] per-channel request level; dropping it cancels
//   value  : [N*W-1:0] per-channel timeout, channel i at [i*W +: W]
//   grant  : [N-1:0] one-hot owner, zero when the timer is free
//   done   : [N-1:0] one-hot one-cycle expiry pulse to the owner
//   busy   : high while a channel owns the timer
//   count  : [W-1:0] remaining ticks, zero when idle
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | timer free; round-robin scan from ptr, load winner's value
// RUN   | counting down on tick; cancel if the owner drops req
// FIRE  | done pulse cycle; advance ptr past owner, then back to IDLE.
//       | A zero timeout enters FIRE still granted and emits done on the
//       | following edge, so done lands one edge after the grant.
module alarm_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           tick,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] value,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic           busy,
  output logic [W-1:0]   count
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {IDLE, RUN, FIRE} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;

  logic          found;
  logic [PW-1:0] win;
  logic [W-1:0]  win_val;
  logic [2*N-1:0] rot;
  logic [PW:0]   off;
  logic [PW:0]   sum;
  logic [PW-1:0] owner_nxt;

  // Rotate requests so that bit k corresponds to channel (ptr + k) mod N;
  // the lowest set bit of the rotated vector is the round-robin winner.
  always_comb begin
    found   = 1'b0;
    off     = '0;
    win_val = '0;
    rot     = {req, req} >> ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = (PW+1)'(k);
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
    win = sum[PW-1:0];
    for (int c = 0; c < N; c++) begin
      if (win == PW'(c)) win_val = value[c*W +: W];
    end
  end

  assign owner_nxt = (owner == PW'(N-1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      grant <= '0;
      done  <= '0;
      busy  <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner <= win;
            grant <= ONE << win;
            busy  <= 1'b1;
            count <= win_val;
            state <= (win_val != '0) ? RUN : FIRE;
          end
        end
        RUN: begin
          // Cancel wins over an expiry at the same edge.
          if (!req[owner]) begin
            grant <= '0;
            busy  <= 1'b0;
            count <= '0;
            ptr   <= owner_nxt;
            state <= IDLE;
          end else if (tick && count != '0) begin
            if (count == W'(1)) begin
              done  <= ONE << owner;
              grant <= '0;
              busy  <= 1'b0;
              count <= '0;
              state <= FIRE;
            end else begin
              count <= count - 1'b1;
            end
          end
        end
        FIRE: begin
          if (busy) begin
            // Zero timeout: still granted, expire now.
            done  <= ONE << owner;
            grant <= '0;
            busy  <= 1'b0;
          end else begin
            done  <= '0;
            ptr   <= owner_nxt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alarm_arbiter.md
# alarm_arbiter

Shares one W-bit countdown alarm between N requesters. Each requester posts a timeout value. The block grants the timer to one requester at a time using round-robin priority, counts the value down on a `tick` enable, and returns a one-cycle `done` pulse to the owner when the timeout expires. It sits between software-visible timer channels and the prescaler that drives `tick`, and it replaces one alarm instance per channel.

## Interface
- `N`, default 4: number of requesters, with N ≥ 2.
- `W`, default 8: countdown width.
- `clock` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high; clears all state.
- `tick` input, 1 bit: count enable, usually from a prescaler; it may be tied high.
- `req` input, N bits: per-channel request level. Holding it high means "timer wanted"; dropping it means cancel.
- `value` input, N*W bits: per-channel timeout. Channel i uses bits [i*W +: W]. The value is sampled only at grant.
- `grant` output, N bits: one-hot owner of the timer. It is all-zero when the timer is free.
- `done` output, N bits: one-hot, one-cycle pulse to the owner on expiry.
- `busy` output, 1 bit: high while a channel owns the timer.
- `count` output, W bits: remaining ticks of the current timeout. It is 0 when the timer is idle.

## Operation
- FSM states: IDLE, RUN, FIRE. Internal state also holds a round-robin pointer `ptr` (0..N-1) and an owner index.
- IDLE, when at least one `req` bit is high:
  - Choose the first set bit scanning ptr, ptr+1, …, wrapping modulo N.
  - Set `grant` to the winner's one-hot bit and `busy` to 1.
  - Set `count` to the winner's `value` slice.
  - Go to RUN if that value is nonzero, otherwise go to FIRE.
- IDLE with no request: hold all state.
- RUN:
  - On `tick`, decrement `count` by 1.
  - If `tick` arrives and `count == 1`: go to FIRE, set `count` to 0, set `done` to the owner bit, and set `grant` and `busy` to 0.
  - Without `tick`, hold.
- Cancel in RUN: if `req[owner]` is low at any edge, return to IDLE. Clear `grant`, `busy` and `count`, do not pulse `done`, and set `ptr` to owner+1 mod N. Cancel takes priority over an expiry at the same edge.
- FIRE (one cycle): clear `done`, set `ptr` to owner+1 mod N, go to IDLE.
- Requester contract:
  - Drop `req` at the edge where it samples `done` high.
  - A `req` still high in the following IDLE cycle is a new request, which gives periodic re-arm. Because `ptr` has moved past this channel, it is served only after the other pending channels.
- Changes to `value` after grant have no effect on the running timeout.
- Arithmetic:
  - `count` never wraps. It decrements only while nonzero in RUN.
  - A value of 1 fires on the first tick. A value of 2^W−1 fires on tick 2^W−1.
- Invariants:
  - `grant` and `done` are never both nonzero in the same cycle.
  - Each is zero or one-hot.
  - `busy` equals the OR-reduction of `grant`.

## Timing
- Reset values, applied asynchronously: state IDLE, `ptr` 0, `grant` 0, `done` 0, `busy` 0, `count` 0.
- All outputs are registered. No combinational path exists from an input to an output.
- Grant latency: `req` first sampled high at edge k in IDLE gives `grant` valid after edge k.
- Expiry latency: with `tick` tied high and value V ≥ 1, `done` is high after edge k+V, i.e. in the cycle that starts V edges after the grant edge.
  - With value 0, `done` is high after edge k+1.
- Turnaround: every service includes one FIRE cycle followed by at least one IDLE cycle. The next grant appears no earlier than 2 edges after `done` rises.
- Cancel latency: `req[owner]` sampled low at edge m gives `grant` and `busy` cleared after edge m.
- A `tick` in IDLE or FIRE is ignored.
- Reset asserted mid-RUN or during FIRE clears everything immediately. `done` is not emitted.

## Test plan
- Single channel: N=4, W=8, `tick`=1, req[2]=1 with value 5 → `grant`=4'b0100 one cycle later; `count` reads 5,4,3,2,1; `done`=4'b0100 for exactly one cycle, 5 edges after grant; `busy` low at `done`.
- Round-robin: `req`=4'b1011 all held, each with value 3 and periodic re-arm → grant order is channel 0, 1, 3, 0, 1, …. Channel 2 is never granted. Each `done` is followed by one IDLE cycle.
- Prescaled tick: `tick` high one cycle in 4, value 3 → `done` arrives after the third tick. `count` holds between ticks.
- Boundaries:
  - value 0 → `done` one cycle after grant.
  - value 8'hFF with `tick`=1 → `done` 255 edges after grant.
  - `count` never underflows.
- Cancel: channel 1 granted with value 10; drop req[1] when `count`=4 → `grant` and `busy` clear next edge, no `done`; pending channel 2 is granted 1 cycle later.
- Async reset mid-RUN: assert `reset` between edges while `count`=6 → all outputs are 0 immediately. After release, the next grant scan starts from channel 0.
